ir_decode_alu: RTL and testbench
================================

Name: ir_decode_alu

Overview:
- Front-end datapath slice of the 16-bit multicycle processor.
- Holds the 10-bit instruction register and decodes it into opcode and one-hot X/Y register selects.
- Provides the combinational ALU (add/sub/and/slt/sll/srl) that feeds the G register.
- Sits between the DIN/bus datapath and the proc control FSM, which drives IRin, dec_en and alu_op.

Parameters:
- None. Data width is fixed at 16 bits and IR width at 10 bits.

Ports:
- Clock  input  1  system clock; IR updates on the rising edge.
- Resetn  input  1  asynchronous active-low reset.
- DIN  input  16  instruction/data input; only DIN[9:0] is loaded into IR.
- IRin  input  1  IR load enable.
- dec_en  input  1  decoder enable; when 0, xsel and ysel are all zeros.
- alu_op  input  3  ALU operation select.
- A  input  16  ALU operand A (from the A register).
- B  input  16  ALU operand B (from the bus).
- IR  output  10  instruction register contents.
- I  output  4  opcode, equal to IR[3:0].
- xsel  output  8  one-hot decode of IR[6:4].
- ysel  output  8  one-hot decode of IR[9:7].
- G  output  16  ALU result (combinational).
- zero  output  1  high when G == 16'h0000.

Behaviour:
- Instruction register:
  - Resetn = 0 forces IR to 10'b0 immediately, independent of Clock.
  - Reset dominates IRin.
  - On a rising Clock with Resetn = 1 and IRin = 1: IR <= DIN[9:0].
  - With IRin = 0, IR holds its value. DIN[15:10] is ignored.
  - Reset values: IR = 0, I = 0; xsel = ysel = 8'b1000_0000 when dec_en = 1.
- Opcode map carried in I (used by the control FSM; no action inside this block):
  - 0 mv, 1 mvi, 2 add, 3 sub, 4 and, 5 slt, 6 sll, 7 srl, 8 ld, 9 sd, 10 mvnz.
- Decoders (combinational, bit 7 = R0):
  - Field value n drives bit (7-n) high: 000 -> 8'b1000_0000, 001 -> 8'b0100_0000, ..., 111 -> 8'b0000_0001.
  - xsel decodes IR[6:4]; ysel decodes IR[9:7].
  - Exactly one bit is high when dec_en = 1; all zeros when dec_en = 0.
- ALU (combinational, 16-bit, no registers):
  - 000 add: G = A + B, modulo 2^16, carry discarded.
  - 001 sub: G = A - B, modulo 2^16, borrow discarded.
  - 010 and: G = A & B.
  - 011 slt: G = 16'h0001 if A < B (unsigned compare), else 16'h0000.
  - 100 sll: G = A << B, logical, full 16-bit shift amount; any B >= 16 gives 0.
  - 101 srl: G = A >> B, logical, zero-fill; any B >= 16 gives 0.
  - 110, 111: G = 16'h0000.
  - G and zero settle within the same cycle as an input change; no latency.
- Decoder and ALU paths are independent of Clock and Resetn. During reset the ALU still computes from A, B and alu_op.
- There is no handshake; the control FSM owns sequencing.

Test Plan:
- Resetn=0 async pulse with IR previously 10'h3FF -> IR=0, I=0 before the next edge; xsel=ysel=8'h80 with dec_en=1.
- DIN=16'hFC45, IRin=1, one edge -> IR=10'h045, I=4'h5, xsel=8'h08 (field 4), ysel=8'h80 (field 0). Then IRin=0, DIN=16'h0000, one edge -> IR unchanged.
- Decoder sweep: DIN[9:4] = {y,x} for all 64 combinations -> one-hot outputs match the (7-n) mapping. dec_en=0 -> xsel=ysel=0.
- Add/sub: A=16'hFFFF, B=1 add -> G=0, zero=1. A=3, B=5 sub -> G=16'hFFFE, zero=0.
- Logic/compare: A=16'hF0F0, B=16'h0FF0 and -> G=16'h00F0. A=2, B=16'h8000 slt -> G=1. A=16'h8000, B=2 slt -> G=0.
- Shifts and illegal ops:
  - A=16'h0001, B=15 sll -> G=16'h8000; B=16 -> G=0.
  - A=16'h8000, B=15 srl -> G=1.
  - alu_op=3'b110 -> G=0, zero=1.

Source files
------------

// File: rtl/ir_decode_alu.sv
// ir_decode_alu
//   Front-end datapath slice of the 16-bit multicycle processor. It holds
//   the 10-bit instruction register and decodes it into an opcode and
//   one-hot X/Y register selects. It also provides the combinational ALU
//   that feeds the G register. The proc control FSM drives IRin, dec_en
//   and alu_op, and owns all sequencing.
//
// Ports
//   Clock   in   1   system clock, IR updates on the rising edge
//   Resetn  in   1   asynchronous active-low reset
//   DIN     in  16   instruction/data input, only DIN[9:0] is loaded
//   IRin    in   1   IR load enable
//   dec_en  in   1   decoder enable, selects are all zeros when low
//   alu_op  in   3   ALU operation select
//   A       in  16   ALU operand A (from the A register)
//   B       in  16   ALU operand B (from the bus)
//   IR      out 10   instruction register contents
//   I       out  4   opcode, IR[3:0]
//   xsel    out  8   one-hot decode of IR[6:4], bit 7 = R0
//   ysel    out  8   one-hot decode of IR[9:7], bit 7 = R0
//   G       out 16   combinational ALU result
//   zero    out  1   high when G is all zeros

module ir_decode_alu (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [15:0] DIN,
  input  logic        IRin,
  input  logic        dec_en,
  input  logic [2:0]  alu_op,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [9:0]  IR,
  output logic [3:0]  I,
  output logic [7:0]  xsel,
  output logic [7:0]  ysel,
  output logic [15:0] G,
  output logic        zero
);

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_SLT  = 3'b011,
    ALU_SLL  = 3'b100,
    ALU_SRL  = 3'b101
  } alu_op_e;

  // The upper DIN bits carry data for other instructions and are never
  // part of the instruction word held here.
  logic unused_din;
  assign unused_din = ^DIN[15:10];

  // Instruction register: reset clears it immediately and wins over a
  // load; otherwise DIN[9:0] is captured on a rising edge when IRin is
  // asserted and held at all other times.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      IR <= '0;
    end else if (IRin) begin
      IR <= DIN[9:0];
    end
  end

  assign I = IR[3:0];

  // Register-select decoders: field value n lights bit (7-n), so R0 sits
  // on the MSB. Shifting a single MSB right by the field gives exactly
  // that mapping. Both selects are forced to zero when disabled.
  always_comb begin
    xsel = 8'h00;
    ysel = 8'h00;
    if (dec_en) begin
      xsel = 8'h80 >> IR[6:4];
      ysel = 8'h80 >> IR[9:7];
    end
  end

  // ALU: purely combinational. Shift amounts use the whole of B, so any
  // amount of 16 or more flushes the result to zero; only the low four
  // bits are fed to the shifter once that case is excluded. Unused
  // opcodes produce zero.
  always_comb begin
    G = 16'h0000;
    case (alu_op)
      ALU_ADD: G = A + B;
      ALU_SUB: G = A - B;
      ALU_AND: G = A & B;
      ALU_SLT: G = {15'b0, (A < B)};
      ALU_SLL: G = (|B[15:4]) ? 16'h0000 : (A << B[3:0]);
      ALU_SRL: G = (|B[15:4]) ? 16'h0000 : (A >> B[3:0]);
      default: G = 16'h0000;
    endcase
  end

  assign zero = (G == 16'h0000);

endmodule

// File: tb/tb_ir_decode_alu.sv
// tb_ir_decode_alu
//   Self-checking bench for ir_decode_alu. A behavioural model computes
//   the expected IR, decodes and ALU result with plain integer arithmetic;
//   directed cases cover the reset pulse, load/hold, decoder sweep and
//   ALU boundary values, followed by randomized cycles.

module tb_ir_decode_alu;

  logic        Clock;
  logic        Resetn;
  logic [15:0] DIN;
  logic        IRin;
  logic        dec_en;
  logic [2:0]  alu_op;
  logic [15:0] A;
  logic [15:0] B;
  logic [9:0]  IR;
  logic [3:0]  I;
  logic [7:0]  xsel;
  logic [7:0]  ysel;
  logic [15:0] G;
  logic        zero;

  int numCompared;
  int numMismatched;
  logic [9:0] modelIr;

  ir_decode_alu dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .DIN    (DIN),
    .IRin   (IRin),
    .dec_en (dec_en),
    .alu_op (alu_op),
    .A      (A),
    .B      (B),
    .IR     (IR),
    .I      (I),
    .xsel   (xsel),
    .ysel   (ysel),
    .G      (G),
    .zero   (zero)
  );

  // 10 ns clock period
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Single comparison point: counts every check, reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference ALU from the arithmetic definitions, on 64-bit integers
  function automatic logic [15:0] refAlu(input int op, input longint a, input longint b);
    longint r;
    case (op)
      0: r = (a + b) % 65536;
      1: r = (a - b + 65536) % 65536;
      2: r = a & b;
      3: r = (a < b) ? 1 : 0;
      4: r = (b >= 16) ? 0 : (a * (longint'(1) << b)) % 65536;
      5: r = (b >= 16) ? 0 : a / (longint'(1) << b);
      default: r = 0;
    endcase
    return r[15:0];
  endfunction

  // One-hot select for register number n, R0 on bit 7
  function automatic logic [7:0] refSel(input int n, input logic en);
    int v;
    if (!en) return 8'h00;
    v = 1;
    for (int k = 0; k < 7 - n; k++) v = v * 2;
    return v[7:0];
  endfunction

  // Compare every output with the model for the current inputs
  task automatic checkAll(input string tag);
    logic [15:0] expG;
    expG = refAlu(int'(alu_op), longint'(A), longint'(B));
    checkOutput({tag, ".IR"}, 32'(IR), 32'(modelIr));
    checkOutput({tag, ".I"}, 32'(I), 32'(modelIr % 16));
    checkOutput({tag, ".xsel"}, 32'(xsel), 32'(refSel((int'(modelIr) / 16) % 8, dec_en)));
    checkOutput({tag, ".ysel"}, 32'(ysel), 32'(refSel(int'(modelIr) / 128, dec_en)));
    checkOutput({tag, ".G"}, 32'(G), 32'(expG));
    checkOutput({tag, ".zero"}, 32'(zero), 32'(expG == 16'h0000));
  endtask

  // Drive one cycle of inputs away from the edge, clock it, update model
  task automatic applyStimulus(input logic [15:0] din, input logic irin,
                               input logic dec, input logic [2:0] op,
                               input logic [15:0] a, input logic [15:0] b);
    @(negedge Clock);
    DIN = din; IRin = irin; dec_en = dec; alu_op = op; A = a; B = b;
    @(posedge Clock);
    if (irin) modelIr = din[9:0];
    #1;
  endtask

  // Combinational ALU setup without clocking
  task automatic setAlu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    alu_op = op; A = a; B = b;
    #1;
  endtask

  initial begin
    numCompared = 0;
    numMismatched = 0;
    modelIr = '0;
    Resetn = 1'b0;
    DIN = '0; IRin = 1'b0; dec_en = 1'b1; alu_op = 3'd0; A = '0; B = '0;

    #2;
    checkOutput("rst_ir", 32'(IR), 32'h0);
    checkOutput("rst_xsel", 32'(xsel), 32'h80);
    checkOutput("rst_ysel", 32'(ysel), 32'h80);
    #10 Resetn = 1'b1;

    // Async reset pulse from IR = 3FF, checked before the next edge
    applyStimulus(16'h03FF, 1'b1, 1'b1, 3'd0, 16'h0, 16'h0);
    checkOutput("load_3ff", 32'(IR), 32'h3FF);
    @(negedge Clock);
    Resetn = 1'b0;
    modelIr = '0;
    #1;
    checkOutput("async_rst_ir", 32'(IR), 32'h0);
    checkOutput("async_rst_i", 32'(I), 32'h0);
    checkOutput("async_rst_xsel", 32'(xsel), 32'h80);
    checkOutput("async_rst_ysel", 32'(ysel), 32'h80);
    #1 Resetn = 1'b1;

    // Reset dominates an active load
    @(negedge Clock);
    Resetn = 1'b0; IRin = 1'b1; DIN = 16'h0155;
    @(posedge Clock); #1;
    checkOutput("rst_over_load", 32'(IR), 32'h0);
    Resetn = 1'b1; IRin = 1'b0;

    // Load FC45, then hold with IRin low
    applyStimulus(16'hFC45, 1'b1, 1'b1, 3'd0, 16'h0, 16'h0);
    checkOutput("fc45_ir", 32'(IR), 32'h045);
    checkOutput("fc45_i", 32'(I), 32'h5);
    checkOutput("fc45_xsel", 32'(xsel), 32'h08);
    checkOutput("fc45_ysel", 32'(ysel), 32'h80);
    applyStimulus(16'h0000, 1'b0, 1'b1, 3'd0, 16'h0, 16'h0);
    checkOutput("hold_ir", 32'(IR), 32'h045);

    // Decoder sweep over all {y,x}, both enable states
    for (int f = 0; f < 64; f++) begin
      applyStimulus(16'(f * 16 + (f % 11)), 1'b1, 1'b1, 3'd2, 16'h0, 16'h0);
      checkAll("sweep");
      dec_en = 1'b0; #1;
      checkOutput("sweep_off_x", 32'(xsel), 32'h0);
      checkOutput("sweep_off_y", 32'(ysel), 32'h0);
    end

    // ALU boundary cases
    setAlu(3'd0, 16'hFFFF, 16'h0001);
    checkOutput("add_wrap_g", 32'(G), 32'h0);
    checkOutput("add_wrap_z", 32'(zero), 32'h1);
    setAlu(3'd1, 16'h0003, 16'h0005);
    checkOutput("sub_wrap_g", 32'(G), 32'hFFFE);
    checkOutput("sub_wrap_z", 32'(zero), 32'h0);
    setAlu(3'd2, 16'hF0F0, 16'h0FF0);
    checkOutput("and_g", 32'(G), 32'h00F0);
    setAlu(3'd3, 16'h0002, 16'h8000);
    checkOutput("slt_true", 32'(G), 32'h1);
    setAlu(3'd3, 16'h8000, 16'h0002);
    checkOutput("slt_false", 32'(G), 32'h0);
    setAlu(3'd4, 16'h0001, 16'd15);
    checkOutput("sll_15", 32'(G), 32'h8000);
    setAlu(3'd4, 16'h0001, 16'd16);
    checkOutput("sll_16", 32'(G), 32'h0);
    setAlu(3'd4, 16'hFFFF, 16'h0100);
    checkOutput("sll_big", 32'(G), 32'h0);
    setAlu(3'd5, 16'h8000, 16'd15);
    checkOutput("srl_15", 32'(G), 32'h1);
    setAlu(3'd5, 16'hFFFF, 16'd16);
    checkOutput("srl_16", 32'(G), 32'h0);
    setAlu(3'd6, 16'h1234, 16'h5678);
    checkOutput("op6_g", 32'(G), 32'h0);
    checkOutput("op6_z", 32'(zero), 32'h1);
    setAlu(3'd7, 16'hFFFF, 16'hFFFF);
    checkOutput("op7_g", 32'(G), 32'h0);

    // ALU keeps working while reset is held
    Resetn = 1'b0; modelIr = '0;
    setAlu(3'd0, 16'h1111, 16'h2222);
    checkOutput("alu_in_rst", 32'(G), 32'h3333);
    Resetn = 1'b1;

    // Randomized cycles
    for (int n = 0; n < 400; n++) begin
      logic [15:0] rb;
      rb = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      applyStimulus(16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                    3'($urandom_range(0, 7)), 16'($urandom), rb);
      checkAll("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
